neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac_pkg.sv | 28 ++
 rtl/neuron_mac_sat_adder.sv | 43 ++++
 rtl/neuron_mac.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// ---------------------------------------------------------------------------
// neuron_mac_pkg
// Shared definitions for the neuron multiply-accumulate block.
//   DATA_WIDTH  : default signed activation / weight width
//   satMax()    : largest positive value of a signed number of given width
//   satMin()    : most negative value (as a bit pattern) of the same width
//   macState_e  : accumulate / bias-add FSM states
// ---------------------------------------------------------------------------
package neuron_mac_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    // Saturation limits are returned 64 bits wide; callers slice off the
    // low 'width' bits, which gives 0x7F..F and 0x80..0 respectively.
    function automatic logic [63:0] satMax(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] satMin(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_BIAS  = 1'b1
    } macState_e;

endpackage

// File: rtl/neuron_mac_sat_adder.sv
// ---------------------------------------------------------------------------
// sat_adder
// Combinational signed adder that clamps to the representable range instead
// of wrapping.
//   a_i, b_i : signed operands, width bits
//   sum_o    : saturated signed sum, width bits
// ---------------------------------------------------------------------------
module sat_adder
    import neuron_mac_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic signed [width-1:0] a_i,
    input  logic signed [width-1:0] b_i,
    output logic signed [width-1:0] sum_o
);

    localparam logic [63:0]       MAX_WIDE = satMax(width);
    localparam logic [63:0]       MIN_WIDE = satMin(width);
    localparam logic [width-1:0] SAT_MAX  = MAX_WIDE[width-1:0];
    localparam logic [width-1:0] SAT_MIN  = MIN_WIDE[width-1:0];

    logic signed [width-1:0] rawSum;
    logic                     posOverflow;
    logic                     negOverflow;

    assign rawSum = a_i + b_i;

    // Overflow is only possible when both operands share a sign and the
    // wrapped result comes out with the opposite sign.
    assign posOverflow = ~a_i[width-1] & ~b_i[width-1] &  rawSum[width-1];
    assign negOverflow =  a_i[width-1] &  b_i[width-1] & ~rawSum[width-1];

    always_comb begin
        sum_o = rawSum;
        if (posOverflow) begin
            sum_o = SAT_MAX;
        end else if (negOverflow) begin
            sum_o = SAT_MIN;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac
// One neuron: multiplies a stream of signed activations by weights fetched
// from an external registered memory, accumulates with saturation, then adds
// a bias and presents the saturated result with a one-cycle valid pulse.
//   clk, rst      : clock and synchronous active-high reset
//   myinput       : signed activation, qualified by myinputValid
//   ren, radd     : weight memory read strobe and address
//   wout          : weight data, arrives one cycle after ren
//   bias          : signed bias, sampled during the BIAS cycle
//   out, outvalid : saturated neuron sum and its update pulse
// numWeight must be at least 2 so the last product of one vector can never
// land in the same cycle as the BIAS state.
// ---------------------------------------------------------------------------
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [dataWidth-1:0]     myinput,
    input  logic                            myinputValid,
    output logic                            ren,
    output logic        [addressWidth-1:0]  radd,
    input  logic signed [dataWidth-1:0]     wout,
    input  logic signed [2*dataWidth-1:0]   bias,
    output logic signed [2*dataWidth-1:0]   out,
    output logic                            outvalid
);

    localparam int ACC_WIDTH = 2 * dataWidth;
    localparam int CNT_WIDTH = $clog2(numWeight + 1);
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
    localparam logic [CNT_WIDTH-1:0]    LAST_CNT  = CNT_WIDTH'(numWeight - 1);

    logic        [addressWidth-1:0] rcnt_q, rcnt_d;
    logic signed [dataWidth-1:0]    myinputD_q;
    logic                           inputValidD_q;
    logic signed [ACC_WIDTH-1:0]    mul_q;
    logic                           mulValid_q;
    logic signed [ACC_WIDTH-1:0]    sum_q, sum_d;
    logic        [CNT_WIDTH-1:0]    accCnt_q, accCnt_d;
    macState_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    out_q, out_d;
    logic                           outvalid_q, outvalid_d;

    logic signed [ACC_WIDTH-1:0]    inputExt;
    logic signed [ACC_WIDTH-1:0]    weightExt;
    logic signed [ACC_WIDTH-1:0]    product;
    logic signed [ACC_WIDTH-1:0]    accSum;
    logic signed [ACC_WIDTH-1:0]    biasSum;

    // The read strobe is a straight wire so the memory sees the request in
    // the same cycle as the activation; reads issued in reset are harmless
    // because every pipeline stage is cleared anyway.
    assign ren      = myinputValid;
    assign radd     = rcnt_q;
    assign out      = out_q;
    assign outvalid = outvalid_q;

    // Operands are sign-extended to the accumulator width before the
    // multiply so the full-precision product is kept.
    assign inputExt  = ACC_WIDTH'(myinputD_q);
    assign weightExt = ACC_WIDTH'(wout);
    assign product   = inputExt * weightExt;

    sat_adder #(
        .width (ACC_WIDTH)
    ) u_accAdder (
        .a_i   (sum_q),
        .b_i   (mul_q),
        .sum_o (accSum)
    );

    sat_adder #(
        .width (ACC_WIDTH)
    ) u_biasAdder (
        .a_i   (sum_q),
        .b_i   (bias),
        .sum_o (biasSum)
    );

    // Read address walks through the weight table once per valid input and
    // wraps so the next vector starts again at weight 0.
    always_comb begin
        rcnt_d = rcnt_q;
        if (myinputValid) begin
            if (rcnt_q == LAST_ADDR) begin
                rcnt_d = '0;
            end else begin
                rcnt_d = rcnt_q + addressWidth'(1);
            end
        end
    end

    // Accumulate / bias FSM. In BIAS the finished sum is combined with the
    // bias, and the accumulator is reseeded with any product of the next
    // vector that is already in flight, so vectors can run back to back.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        accCnt_d   = accCnt_q;
        out_d      = out_q;
        outvalid_d = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (mulValid_q) begin
                    sum_d = accSum;
                    if (accCnt_q == LAST_CNT) begin
                        accCnt_d = '0;
                        state_d  = ST_BIAS;
                    end else begin
                        accCnt_d = accCnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            ST_BIAS: begin
                out_d      = biasSum;
                outvalid_d = 1'b1;
                state_d    = ST_ACCUM;
                if (mulValid_q) begin
                    sum_d    = mul_q;
                    accCnt_d = CNT_WIDTH'(1);
                end else begin
                    sum_d    = '0;
                    accCnt_d = '0;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // All state: the activation delay stage lines myinput up with the
    // registered weight, then the product register feeds the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q        <= '0;
            myinputD_q    <= '0;
            inputValidD_q <= 1'b0;
            mul_q         <= '0;
            mulValid_q    <= 1'b0;
            sum_q         <= '0;
            accCnt_q      <= '0;
            state_q       <= ST_ACCUM;
            out_q         <= '0;
            outvalid_q    <= 1'b0;
        end else begin
            rcnt_q        <= rcnt_d;
            myinputD_q    <= myinput;
            inputValidD_q <= myinputValid;
            mul_q         <= product;
            mulValid_q    <= inputValidD_q;
            sum_q         <= sum_d;
            accCnt_q      <= accCnt_d;
            state_q       <= state_d;
            out_q         <= out_d;
            outvalid_q    <= outvalid_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac
// Directed bench for neuron_mac with four weights and 16-bit data. A
// registered weight memory model answers ren/radd, a monitor records every
// outvalid pulse with its cycle number, and each scenario checks the
// recorded pulses against hand-computed sums and latencies.
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int NUM_W = 4;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic                   clk;
    logic                   rst;
    logic signed [DW-1:0]   myinput;
    logic                   myinputValid;
    logic                   ren;
    logic        [AW-1:0]   radd;
    logic signed [DW-1:0]   wout;
    logic signed [2*DW-1:0] bias;
    logic signed [2*DW-1:0] out;
    logic                   outvalid;

    logic signed [DW-1:0]   weightMem [NUM_W];

    int          cyc;
    int          lastEdge;
    int          firstEdge;
    int          compareCount;
    int          failCount;
    logic [31:0] pulseOut [$];
    int          pulseCyc [$];

    neuron_mac #(
        .numWeight    (NUM_W),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .myinput      (myinput),
        .myinputValid (myinputValid),
        .ren          (ren),
        .radd         (radd),
        .wout         (wout),
        .bias         (bias),
        .out          (out),
        .outvalid     (outvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle count of rising edges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External weight memory with a one-cycle registered read.
    initial wout = '0;
    always @(posedge clk) begin
        if (ren) begin
            wout <= weightMem[radd[1:0]];
        end
    end

    // Records every result pulse together with the edge count it follows.
    always @(negedge clk) begin
        if (outvalid) begin
            pulseOut.push_back(out);
            pulseCyc.push_back(cyc);
        end
    end

    // Counts the comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of input on the falling edge; when valid, the read
    // strobe and the address the DUT presents for this input are checked.
    task automatic applyStimulus(input logic signed [DW-1:0] value, input logic valid,
                                 input int expRadd);
        @(negedge clk);
        myinput      = value;
        myinputValid = valid;
        if (valid) lastEdge = cyc + 1;
        #1;
        checkOutput("ren", 32'(ren), 32'(valid));
        if (valid) checkOutput("radd", 32'(radd), 32'(expRadd));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, 1'b0, 0);
    endtask

    task automatic driveVector(input logic signed [DW-1:0] value, input int gap);
        for (int i = 0; i < NUM_W; i++) begin
            applyStimulus(value, 1'b1, i);
            for (int g = 0; g < gap; g++) applyStimulus('0, 1'b0, 0);
        end
    endtask

    task automatic setWeights(input logic signed [DW-1:0] w0, input logic signed [DW-1:0] w1,
                              input logic signed [DW-1:0] w2, input logic signed [DW-1:0] w3);
        weightMem[0] = w0;
        weightMem[1] = w1;
        weightMem[2] = w2;
        weightMem[3] = w3;
    endtask

    task automatic clearPulses();
        pulseOut.delete();
        pulseCyc.delete();
    endtask

    // Expects exactly one recorded pulse with the given value, arriving
    // three edges after the edge that sampled the last input.
    task automatic checkSinglePulse(input string tag, input logic [31:0] expOut);
        checkOutput({tag, "_pulses"}, 32'(pulseOut.size()), 32'd1);
        if (pulseOut.size() > 0) begin
            checkOutput({tag, "_out"}, pulseOut[0], expOut);
            checkOutput({tag, "_latency"}, 32'(pulseCyc[0]), 32'(lastEdge + 3));
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        lastEdge     = 0;
        firstEdge    = 0;
        rst          = 1'b1;
        myinput      = '0;
        myinputValid = 1'b1;
        bias         = '0;
        setWeights(16'sd1, 16'sd2, 16'sd3, 16'sd4);

        // Reset state, with a read request held active through reset.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ren", 32'(ren), 32'd1);
        checkOutput("rst_radd", 32'(radd), 32'd0);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_outvalid", 32'(outvalid), 32'd0);
        @(negedge clk);
        myinputValid = 1'b0;
        rst          = 1'b0;
        idle(2);
        checkOutput("post_rst_radd", 32'(radd), 32'd0);

        // Basic vector: 1+2+3+4 plus bias 10.
        clearPulses();
        bias = 32'sd10;
        driveVector(16'sd1, 0);
        idle(8);
        checkSinglePulse("basic", 32'd20);
        idle(3);
        checkOutput("basic_hold", out, 32'd20);

        // Same vector with two idle cycles after every input.
        clearPulses();
        driveVector(16'sd1, 2);
        idle(8);
        checkSinglePulse("gapped", 32'd20);

        // Positive saturation of the accumulator.
        clearPulses();
        bias = '0;
        setWeights(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
        driveVector(16'sh7FFF, 0);
        idle(8);
        checkSinglePulse("pos_sat", 32'h7FFF_FFFF);

        // Negative saturation of the accumulator.
        clearPulses();
        setWeights(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
        driveVector(16'sh7FFF, 0);
        idle(8);
        checkSinglePulse("neg_sat", 32'h8000_0000);

        // Two vectors with no gap between them.
        clearPulses();
        setWeights(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        driveVector(16'sd1, 0);
        firstEdge = lastEdge;
        driveVector(16'sd2, 0);
        idle(10);
        checkOutput("b2b_pulses", 32'(pulseOut.size()), 32'd2);
        if (pulseOut.size() > 1) begin
            checkOutput("b2b_out0", pulseOut[0], 32'd10);
            checkOutput("b2b_lat0", 32'(pulseCyc[0]), 32'(firstEdge + 3));
            checkOutput("b2b_out1", pulseOut[1], 32'd20);
            checkOutput("b2b_lat1", 32'(pulseCyc[1]), 32'(lastEdge + 3));
            checkOutput("b2b_spacing", 32'(pulseCyc[1] - pulseCyc[0]), 32'd4);
        end

        // Reset after two inputs drops the partial vector.
        clearPulses();
        applyStimulus(16'sd1, 1'b1, 0);
        applyStimulus(16'sd1, 1'b1, 1);
        @(negedge clk);
        myinputValid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_radd", 32'(radd), 32'd0);
        checkOutput("midrst_out", out, 32'd0);
        driveVector(16'sd1, 0);
        idle(8);
        checkSinglePulse("midrst", 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
